// File: rtl/fpu_operand_sequencer.sv
// fpu_operand_sequencer
//   Pairs a stream of 32-bit words (A, then B) from one valid/ready bus and
//   presents them to the FPU through the input_a and input_b stb/ack
//   handshakes. op_sel is captured with the A word and holds until the FPU
//   result has been handed off (output_z stb/ack).
//
// Ports
//   clk, rsto                    clock, async active-high reset
//   in_data/in_op/in_valid       word source; in_op is sampled with the A word
//   in_ready                     a word is accepted this cycle
//   input_a/_stb/_ack            operand A handshake to the FPU
//   input_b/_stb/_ack            operand B handshake to the FPU
//   op_sel                       registered operation select
//   output_z_stb/_ack            FPU result handshake (monitored only)
//   busy                         operation in flight (SEND_A/SEND_B/WAIT_Z)
//   op_count                     completed operations, wraps at 16 bits
//   err_timeout                  sticky watchdog flag
//
// Build option
//   SEQ_TIMEOUT_EN : builds a watchdog that returns the FSM to LOAD_A after
//                    TIMEOUT_CYCLES in one SEND/WAIT state. Without it the
//                    FSM waits indefinitely and err_timeout is tied to 0.
module fpu_operand_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rsto,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_op,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] input_a,
  output logic        input_a_stb,
  input  logic        input_a_ack,
  output logic [31:0] input_b,
  output logic        input_b_stb,
  input  logic        input_b_ack,
  output logic [1:0]  op_sel,
  input  logic        output_z_stb,
  input  logic        output_z_ack,
  output logic        busy,
  output logic [15:0] op_count,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    SEND_A = 3'd3,
    SEND_B = 3'd4,
    WAIT_Z = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] input_a_q, input_a_d;
  logic [31:0] input_b_q, input_b_d;
  logic [1:0]  op_sel_q, op_sel_d;
  logic [15:0] op_count_q, op_count_d;

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_timeout_q, err_timeout_d;
`endif

  always_ff @(posedge clk or posedge rsto) begin
    if (rsto) begin
      state_q    <= IDLE;
      input_a_q  <= '0;
      input_b_q  <= '0;
      op_sel_q   <= '0;
      op_count_q <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      input_a_q  <= input_a_d;
      input_b_q  <= input_b_d;
      op_sel_q   <= op_sel_d;
      op_count_q <= op_count_d;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    input_a_d  = input_a_q;
    input_b_d  = input_b_q;
    op_sel_d   = op_sel_q;
    op_count_d = op_count_q;
`ifdef SEQ_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    err_timeout_d = err_timeout_q;
`endif
    // in_ready is high exactly in LOAD_A/LOAD_B, so in_valid alone marks a
    // transfer in those states.
    case (state_q)
      IDLE:   state_d = LOAD_A;
      LOAD_A: if (in_valid) begin
        state_d   = LOAD_B;
        input_a_d = in_data;
        op_sel_d  = in_op;
`ifdef SEQ_TIMEOUT_EN
        err_timeout_d = 1'b0;
`endif
      end
      LOAD_B: if (in_valid) begin
        state_d   = SEND_A;
        input_b_d = in_data;
      end
      SEND_A: if (input_a_ack) state_d = SEND_B;
      SEND_B: if (input_b_ack) state_d = WAIT_Z;
      WAIT_Z: if (output_z_stb && output_z_ack) begin
        state_d    = LOAD_A;
        op_count_d = op_count_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
`ifdef SEQ_TIMEOUT_EN
    // Counter restarts on every state change; a timed-out state has no exit
    // this cycle, so the op_count increment above never coincides with it.
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (state_q == SEND_A || state_q == SEND_B || state_q == WAIT_Z) begin
      if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d       = LOAD_A;
        err_timeout_d = 1'b1;
        tmo_cnt_d     = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  assign in_ready    = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign input_a_stb = (state_q == SEND_A);
  assign input_b_stb = (state_q == SEND_B);
  assign busy        = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == WAIT_Z);
  assign input_a     = input_a_q;
  assign input_b     = input_b_q;
  assign op_sel      = op_sel_q;
  assign op_count    = op_count_q;

`ifdef SEQ_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
module tb_fpu_operand_sequencer;
  logic        clk = 1'b0;
  logic        rsto;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [1:0]  op_sel;
  logic        output_z_stb;
  logic        output_z_ack;
  logic        busy;
  logic [15:0] op_count;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fpu_operand_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rsto(rsto),
    .in_data(in_data), .in_op(in_op), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .op_sel(op_sel), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
    .busy(busy), .op_count(op_count), .err_timeout(err_timeout)
  );

  // Offers one word starting at a negedge; returns at the negedge after the
  // accepting edge with in_valid dropped.
  task automatic push_word(input logic [31:0] d, input logic [1:0] op);
    bit ok = 0;
    in_data = d; in_op = op; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL push_timeout: in_ready never seen for word %h", d);
    end
  endtask

  // Holds all acks high until the operation completes.
  task automatic drain_op(input string name);
    bit done = 0;
    input_a_ack = 1; input_b_ack = 1; output_z_stb = 1; output_z_ack = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); @(negedge clk);
      if (!busy) done = 1;
    end
    output_z_stb = 0; output_z_ack = 0;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s: operation did not complete in 20 cycles", name);
    end else exp_cnt = (exp_cnt + 1) % 65536;
  endtask

  task automatic test_reset();
    rsto = 1; in_data = 0; in_op = 0; in_valid = 0;
    input_a_ack = 0; input_b_ack = 0; output_z_stb = 0; output_z_ack = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, input_a_stb, input_b_stb, busy, err_timeout} !== 5'b0 ||
        input_a !== 0 || input_b !== 0 || op_sel !== 0 || op_count !== 0) begin
      bad++;
      $display("FAIL reset_vals: rdy=%b sa=%b sb=%b busy=%b a=%h b=%h op=%b cnt=%h, required all 0",
               in_ready, input_a_stb, input_b_stb, busy, input_a, input_b, op_sel, op_count);
    end
    rsto = 0;
    @(negedge clk);
    total++;
    if (in_ready !== 1 || input_a_stb !== 0 || input_b_stb !== 0 || op_count !== 0) begin
      bad++;
      $display("FAIL reset_release: rdy=%b sa=%b sb=%b cnt=%h, required 1 0 0 0",
               in_ready, input_a_stb, input_b_stb, op_count);
    end
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    input_a_ack = 1; input_b_ack = 1;
    push_word(32'h3F800000, 2'b01);
    total++;
    if (in_ready !== 1) begin
      bad++; $display("FAIL back_to_back: in_ready=%b after A, required 1", in_ready);
    end
    push_word(32'h40000000, 2'b10);
    total++;
    if (input_a !== 32'h3F800000 || input_b !== 32'h40000000 || op_sel !== 2'b01 ||
        input_a_stb !== 1 || input_b_stb !== 0 || busy !== 1) begin
      bad++;
      $display("FAIL basic_send_a: a=%h b=%h op=%b sa=%b sb=%b busy=%b, required 3f800000 40000000 01 1 0 1",
               input_a, input_b, op_sel, input_a_stb, input_b_stb, busy);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (input_a_stb !== 0 || input_b_stb !== 1) begin
      bad++; $display("FAIL basic_send_b: sa=%b sb=%b, required 0 1", input_a_stb, input_b_stb);
    end
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (busy !== 1 || input_b_stb !== 0 || in_ready !== 0 || op_count !== 16'(exp_cnt)) begin
        bad++; $display("FAIL basic_wait_z: busy=%b sb=%b rdy=%b cnt=%h, required 1 0 0 %h",
                        busy, input_b_stb, in_ready, op_count, 16'(exp_cnt));
      end
    end
    output_z_stb = 1; output_z_ack = 1;
    @(posedge clk); @(negedge clk);
    output_z_stb = 0; output_z_ack = 0;
    exp_cnt++;
    total++;
    if (busy !== 0 || in_ready !== 1 || op_count !== 16'(exp_cnt)) begin
      bad++; $display("FAIL basic_done: busy=%b rdy=%b cnt=%h, required 0 1 %h",
                      busy, in_ready, op_count, 16'(exp_cnt));
    end
  endtask

  task automatic test_ack_stall();
    input_a_ack = 0; input_b_ack = 0;
    push_word(32'h11112222, 2'b11);
    push_word(32'h33334444, 2'b00);
    in_valid = 1; in_data = 32'hDEADBEEF; in_op = 2'b10;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (input_a_stb !== 1 || in_ready !== 0 || input_b_stb !== 0) begin
        bad++; $display("FAIL stall_cycle%0d: sa=%b rdy=%b sb=%b, required 1 0 0",
                        i, input_a_stb, in_ready, input_b_stb);
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 0;
    total++;
    if (input_a !== 32'h11112222 || input_b !== 32'h33334444 || op_sel !== 2'b11) begin
      bad++; $display("FAIL stall_hold: a=%h b=%h op=%b, required 11112222 33334444 11",
                      input_a, input_b, op_sel);
    end
    drain_op("stall_drain");
    total++;
    if (op_count !== 16'(exp_cnt) || input_a !== 32'h11112222) begin
      bad++; $display("FAIL stall_done: cnt=%h a=%h, required %h 11112222",
                      op_count, input_a, 16'(exp_cnt));
    end
  endtask

  // Random words and random handshake timing; the reference is a simple
  // phase model (A pending -> B pending -> result pending) driven by the
  // acks the bench itself applied.
  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [31:0] ea, eb;
      logic [1:0]  eo;
      bit a_done, b_done, z_done;
      ea = $urandom; eb = $urandom; eo = 2'($urandom_range(0, 3));
      input_a_ack = 0; input_b_ack = 0; output_z_stb = 0; output_z_ack = 0;
      push_word(ea, eo);
      push_word(eb, 2'($urandom_range(0, 3)));
      a_done = 0; b_done = 0; z_done = 0;
      for (int c = 0; c < 300 && !z_done; c++) begin
        input_a_ack  = 1'($urandom_range(0, 1));
        input_b_ack  = 1'($urandom_range(0, 1));
        output_z_stb = 1'($urandom_range(0, 1));
        output_z_ack = 1'($urandom_range(0, 1));
        in_valid     = 1'($urandom_range(0, 1));
        in_data      = $urandom;
        in_op        = 2'($urandom_range(0, 3));
        total++;
        if (input_a !== ea || input_b !== eb || op_sel !== eo || busy !== 1 || in_ready !== 0 ||
            input_a_stb !== !a_done || input_b_stb !== (a_done && !b_done)) begin
          bad++;
          $display("FAIL rand_op%0d_c%0d: a=%h b=%h op=%b busy=%b rdy=%b sa=%b sb=%b, required %h %h %b 1 0 %b %b",
                   n, c, input_a, input_b, op_sel, busy, in_ready, input_a_stb, input_b_stb,
                   ea, eb, eo, !a_done, a_done && !b_done);
        end
        if (!a_done) a_done = input_a_ack;
        else if (!b_done) b_done = input_b_ack;
        else z_done = output_z_stb && output_z_ack;
        @(posedge clk); @(negedge clk);
      end
      in_valid = 0; output_z_stb = 0; output_z_ack = 0;
      if (z_done) exp_cnt = (exp_cnt + 1) % 65536;
      total++;
      if (!z_done || op_count !== 16'(exp_cnt) || busy !== 0 || in_ready !== 1) begin
        bad++; $display("FAIL rand_done%0d: finished=%0d cnt=%h busy=%b rdy=%b, required 1 %h 0 1",
                        n, z_done, op_count, busy, in_ready, 16'(exp_cnt));
      end
    end
  endtask

  task automatic test_wrap();
    force dut.op_count_q = 16'hFFFF;
    #1 release dut.op_count_q;
    exp_cnt = 65535;
    total++;
    if (op_count !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_preload: cnt=%h, required ffff", op_count);
    end
    @(negedge clk);
    push_word(32'h0000_0001, 2'b00);
    push_word(32'h0000_0002, 2'b00);
    drain_op("wrap_drain");
    total++;
    if (op_count !== 16'h0000) begin
      bad++; $display("FAIL wrap: cnt=%h, required 0000", op_count);
    end
  endtask

  task automatic test_timeout();
`ifdef SEQ_TIMEOUT_EN
    input_a_ack = 1; input_b_ack = 0;
    push_word(32'hCAFE0001, 2'b10);
    push_word(32'hCAFE0002, 2'b00);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (input_b_stb !== 1 || err_timeout !== 0) begin
        bad++; $display("FAIL tmo_wait%0d: sb=%b err=%b, required 1 0", i, input_b_stb, err_timeout);
      end
      @(posedge clk); @(negedge clk);
    end
    total++;
    if (err_timeout !== 1 || in_ready !== 1 || input_b_stb !== 0 || op_count !== 16'(exp_cnt)) begin
      bad++; $display("FAIL tmo_fire: err=%b rdy=%b sb=%b cnt=%h, required 1 1 0 %h",
                      err_timeout, in_ready, input_b_stb, op_count, 16'(exp_cnt));
    end
    push_word(32'hCAFE0003, 2'b01);
    total++;
    if (err_timeout !== 0) begin
      bad++; $display("FAIL tmo_clear: err=%b, required 0", err_timeout);
    end
    push_word(32'hCAFE0004, 2'b01);
    drain_op("tmo_drain");
`else
    push_word(32'hCAFE0001, 2'b10);
    push_word(32'hCAFE0002, 2'b00);
    input_a_ack = 1; input_b_ack = 0;
    repeat (40) @(negedge clk);
    total++;
    if (err_timeout !== 0 || input_b_stb !== 1 || op_count !== 16'(exp_cnt)) begin
      bad++; $display("FAIL no_tmo: err=%b sb=%b cnt=%h, required 0 1 %h",
                      err_timeout, input_b_stb, op_count, 16'(exp_cnt));
    end
    drain_op("no_tmo_drain");
`endif
  endtask

  task automatic test_reset_mid();
    input_a_ack = 1; input_b_ack = 1;
    push_word(32'h55555555, 2'b11);
    push_word(32'h66666666, 2'b00);
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1 || input_a_stb !== 0 || input_b_stb !== 0) begin
      bad++; $display("FAIL mid_wait_z: busy=%b sa=%b sb=%b, required 1 0 0", busy, input_a_stb, input_b_stb);
    end
    rsto = 1;
    #1;
    total++;
    if ({in_ready, input_a_stb, input_b_stb, busy, err_timeout} !== 5'b0 ||
        input_a !== 0 || input_b !== 0 || op_sel !== 0 || op_count !== 0) begin
      bad++; $display("FAIL mid_reset: rdy=%b busy=%b a=%h b=%h op=%b cnt=%h, required all 0",
                      in_ready, busy, input_a, input_b, op_sel, op_count);
    end
    exp_cnt = 0;
    @(negedge clk);
    rsto = 0;
    @(negedge clk);
    total++;
    if (in_ready !== 1 || busy !== 0) begin
      bad++; $display("FAIL mid_restart: rdy=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_stall();
    test_random();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
